// File: rtl/dither_pkg.sv
// ---------------------------------------------------------------------------
// dither_pkg
// Shared types and defaults for the dither stream sequencer.
//   dmode_e     : dither mode latched per frame (3 folds to bypass)
//   seq_state_e : line sequencer states
//   map_mode()  : raw cfg_mode -> dmode_e
// ---------------------------------------------------------------------------
package dither_pkg;

  localparam int DEF_PIXEL_RATE   = 4;
  localparam int DEF_FLUSH_CYCLES = 2;

  typedef enum logic [1:0] {
    DM_BYPASS = 2'd0,
    DM_Y4     = 2'd1,
    DM_Y1     = 2'd2
  } dmode_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    VSYNC   = 3'd1,
    WAIT_DE = 3'd2,
    ACTIVE  = 3'd3,
    PAD     = 3'd4,
    FLUSH   = 3'd5
  } seq_state_e;

  // Reserved encoding 3 behaves as bypass downstream, so it is folded here.
  function automatic dmode_e map_mode(input logic [1:0] m);
    case (m)
      2'd1:    return DM_Y4;
      2'd2:    return DM_Y1;
      default: return DM_BYPASS;
    endcase
  endfunction

endpackage

// File: rtl/dither_seq_delay.sv
// ---------------------------------------------------------------------------
// dither_seq_delay
// Fixed-latency delay line, DEPTH register stages of a W-bit bus, cleared by
// the asynchronous reset.
//   clk, rst_n : clock, async active-low reset
//   d_i        : input bus
//   q_o        : d_i delayed DEPTH cycles
// ---------------------------------------------------------------------------
module dither_seq_delay #(
  parameter int W     = 1,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [DEPTH-1:0][W-1:0] vld_pipe_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
    end else begin
      vld_pipe_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) vld_pipe_q[i] <= vld_pipe_q[i-1];
    end
  end

  assign q_o = vld_pipe_q[DEPTH-1];

endmodule

// File: rtl/dither_stream_sequencer.sv
// ---------------------------------------------------------------------------
// dither_stream_sequencer
// Turns raw vsync/hsync/de video timing into the error-diffusion ditherer's
// vsync/hsync/in_valid protocol with a fixed number of pixel groups per line:
// short lines are padded with cfg_fill, long lines are truncated.
//
// Optional build macro DITHER_SEQ_STATS_EN adds frame_cnt / pad_cnt.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   vin_vsync/hsync/de   source timing (hsync unused: line ends come from de)
//   vin_pix              source pixel group
//   cfg_h_groups/mode/fill  per-frame config, sampled on the vsync rising edge
//   dth_vsync            1-cycle frame pulse to the ditherer
//   dth_hsync            held high between lines (clears error registers)
//   dth_in_valid, dth_in ditherer pixel group input
//   mode_q               mode latched for the current frame
//   out_valid            dth_in_valid aligned to the ditherer output register
//   line_short/line_long sticky per-frame pad / truncate flags
//   frame_cnt, pad_cnt   (DITHER_SEQ_STATS_EN only) frame / pad-group counters
// ---------------------------------------------------------------------------
module dither_stream_sequencer
  import dither_pkg::*;
#(
  parameter int PIXEL_RATE   = DEF_PIXEL_RATE,
  parameter int INPUT_BITS   = 8,
  parameter int GBITS        = 10,
  parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             vin_vsync,
  input  logic                             vin_hsync,
  input  logic                             vin_de,
  input  logic [INPUT_BITS*PIXEL_RATE-1:0] vin_pix,
  input  logic [GBITS-1:0]                 cfg_h_groups,
  input  logic [1:0]                       cfg_mode,
  input  logic [INPUT_BITS-1:0]            cfg_fill,
  output logic                             dth_vsync,
  output logic                             dth_hsync,
  output logic                             dth_in_valid,
  output logic [INPUT_BITS*PIXEL_RATE-1:0] dth_in,
  output logic [1:0]                       mode_q,
  output logic                             out_valid,
`ifdef DITHER_SEQ_STATS_EN
  output logic [15:0]                      frame_cnt,
  output logic [15:0]                      pad_cnt,
`endif
  output logic                             line_short,
  output logic                             line_long
);

  localparam int LW = INPUT_BITS * PIXEL_RATE;
  // FLUSH holds FLUSH_CYCLES+1 state cycles: the first one still shows the
  // final group on the registered outputs, the rest are the idle flush.
  localparam int FW = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

  seq_state_e              state_q, state_d;
  logic [GBITS-1:0]        gcnt_q, gcnt_d, hgrp_q, hgrp_d, gnext;
  logic [FW-1:0]           fcnt_q, fcnt_d;
  logic [INPUT_BITS-1:0]   fill_q, fill_d;
  logic [1:0]              mode_d;
  logic                    vs_q, vs_rise;
  logic                    drop_q, drop_d;
  logic                    vld_d, short_d, long_d;
  logic [LW-1:0]           pix_d;
  logic [PIXEL_RATE-1:0][INPUT_BITS-1:0] fill_lanes;
  logic                    unused_hsync;

  assign unused_hsync = vin_hsync;
  assign vs_rise      = vin_vsync & ~vs_q;
  assign gnext        = gcnt_q + GBITS'(1);

  for (genvar l = 0; l < PIXEL_RATE; l++) begin : g_fill
    assign fill_lanes[l] = fill_q;
  end

  // drop_q: the source is still inside a line that already reached its group
  // count; further de groups are excess until de drops.
  always_comb begin
    state_d = state_q;
    gcnt_d  = gcnt_q;
    fcnt_d  = fcnt_q;
    hgrp_d  = hgrp_q;
    fill_d  = fill_q;
    mode_d  = mode_q;
    drop_d  = drop_q & vin_de;
    vld_d   = 1'b0;
    pix_d   = vin_pix;
    short_d = line_short;
    long_d  = line_long;

    if (vs_rise) begin
      // vsync wins over everything, including a coincident de group
      state_d = VSYNC;
      hgrp_d  = cfg_h_groups;
      mode_d  = map_mode(cfg_mode);
      fill_d  = cfg_fill;
      short_d = 1'b0;
      long_d  = 1'b0;
      gcnt_d  = '0;
      fcnt_d  = '0;
      drop_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        VSYNC: begin
          state_d = WAIT_DE;
          gcnt_d  = '0;
        end
        WAIT_DE: begin
          if (vin_de) begin
            if (drop_q || hgrp_q == '0) begin
              long_d = 1'b1;
            end else begin
              vld_d  = 1'b1;
              gcnt_d = GBITS'(1);
              if (hgrp_q == GBITS'(1)) begin
                state_d = FLUSH;
                fcnt_d  = '0;
                drop_d  = 1'b1;
              end else begin
                state_d = ACTIVE;
              end
            end
          end
        end
        ACTIVE, PAD: begin
          // every cycle in a line emits a group: source or fill
          vld_d  = 1'b1;
          gcnt_d = gnext;
          if (state_q == PAD || !vin_de) begin
            pix_d   = fill_lanes;
            short_d = 1'b1;
          end
          if (state_q == PAD && vin_de) long_d = 1'b1;
          if (gnext == hgrp_q) begin
            state_d = FLUSH;
            fcnt_d  = '0;
            drop_d  = vin_de;
          end else if (!vin_de) begin
            state_d = PAD;
          end
        end
        FLUSH: begin
          if (vin_de && drop_q) long_d = 1'b1;
          if (fcnt_q == FW'(FLUSH_CYCLES)) state_d = WAIT_DE;
          else                             fcnt_d  = fcnt_q + FW'(1);
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      gcnt_q       <= '0;
      fcnt_q       <= '0;
      hgrp_q       <= '0;
      fill_q       <= '0;
      vs_q         <= 1'b0;
      drop_q       <= 1'b0;
      dth_vsync    <= 1'b0;
      dth_hsync    <= 1'b0;
      dth_in_valid <= 1'b0;
      dth_in       <= '0;
      mode_q       <= '0;
      line_short   <= 1'b0;
      line_long    <= 1'b0;
    end else begin
      state_q      <= state_d;
      gcnt_q       <= gcnt_d;
      fcnt_q       <= fcnt_d;
      hgrp_q       <= hgrp_d;
      fill_q       <= fill_d;
      vs_q         <= vin_vsync;
      drop_q       <= drop_d;
      dth_vsync    <= (state_d == VSYNC);
      dth_hsync    <= (state_d == WAIT_DE);
      dth_in_valid <= vld_d;
      dth_in       <= pix_d;
      mode_q       <= mode_d;
      line_short   <= short_d;
      line_long    <= long_d;
    end
  end

  // ditherer output register is one stage behind its input
  dither_seq_delay #(.W(1), .DEPTH(1)) u_ovld (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (dth_in_valid),
    .q_o   (out_valid)
  );

`ifdef DITHER_SEQ_STATS_EN
  logic pad_grp;
  assign pad_grp = !vs_rise && ((state_q == PAD) || (state_q == ACTIVE && !vin_de));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      pad_cnt   <= '0;
    end else begin
      if (state_q == VSYNC) frame_cnt <= frame_cnt + 16'd1;
      if (pad_grp && pad_cnt != 16'hFFFF) pad_cnt <= pad_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dither_stream_sequencer.sv
// ---------------------------------------------------------------------------
// tb_dither_stream_sequencer
// Directed bench for dither_stream_sequencer. Expected pixel groups are
// queued when driven and popped when dth_in_valid shows them; control and
// flag outputs are checked at directed points.
// ---------------------------------------------------------------------------
module tb_dither_stream_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vin_vsync = 1'b0, vin_hsync = 1'b0, vin_de = 1'b0;
  logic [31:0] vin_pix = '0;
  logic [9:0]  cfg_h_groups = '0;
  logic [1:0]  cfg_mode = '0;
  logic [7:0]  cfg_fill = '0;
  logic        dth_vsync, dth_hsync, dth_in_valid, out_valid, line_short, line_long;
  logic [31:0] dth_in;
  logic [1:0]  mode_q;

  int          ntests = 0, nfail = 0, vrise = 0;
  logic        prev_vld = 1'b0;
  logic [31:0] sb[$];

  dither_stream_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .vin_vsync    (vin_vsync),
    .vin_hsync    (vin_hsync),
    .vin_de       (vin_de),
    .vin_pix      (vin_pix),
    .cfg_h_groups (cfg_h_groups),
    .cfg_mode     (cfg_mode),
    .cfg_fill     (cfg_fill),
    .dth_vsync    (dth_vsync),
    .dth_hsync    (dth_hsync),
    .dth_in_valid (dth_in_valid),
    .dth_in       (dth_in),
    .mode_q       (mode_q),
    .out_valid    (out_valid),
    .line_short   (line_short),
    .line_long    (line_long)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic grp(input logic [31:0] p, input bit keep);
    vin_de  = 1'b1;
    vin_pix = p;
    if (keep) sb.push_back(p);
    cyc();
  endtask

  task automatic idle(input int n);
    vin_de = 1'b0;
    repeat (n) cyc();
  endtask

  // scoreboard and out_valid alignment monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_vld = 1'b0;
    end else begin
      chk("out_valid_align", {31'd0, out_valid}, {31'd0, prev_vld});
      if (dth_in_valid) begin
        if (!prev_vld) vrise++;
        if (sb.size() == 0) chk("unexpected_valid", {31'd0, dth_in_valid}, 32'd0);
        else                chk("pix", dth_in, sb.pop_front());
      end
      prev_vld = dth_in_valid;
    end
  end

  initial begin
    int   r0;
    logic act;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ctl", {24'd0, dth_vsync, dth_hsync, dth_in_valid, out_valid,
                    line_short, line_long, mode_q}, 32'd0);
    chk("rst_pix", dth_in, 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    @(negedge clk);
    chk("idle_no_hsync", {31'd0, dth_hsync}, 32'd0);

    // frame 1: h=4, mode Y4, fill 0x80
    cfg_h_groups = 10'd4; cfg_mode = 2'd1; cfg_fill = 8'h80;
    vin_vsync = 1'b1;
    cyc();
    @(negedge clk);
    chk("f1_vsync", {31'd0, dth_vsync}, 32'd1);
    chk("f1_mode", {30'd0, mode_q}, 32'd1);
    cyc();
    vin_vsync = 1'b0;
    @(negedge clk);
    chk("f1_vsync_1cyc", {31'd0, dth_vsync}, 32'd0);
    chk("f1_hsync", {31'd0, dth_hsync}, 32'd1);

    // line 1: exact width
    r0 = vrise;
    for (int k = 0; k < 4; k++) grp(32'h10203040 + k * 32'h01010101, 1'b1);
    vin_de = 1'b0;
    cyc(); @(negedge clk);
    chk("flush1", {30'd0, dth_in_valid, dth_hsync}, 32'd0);
    cyc(); @(negedge clk);
    chk("flush2", {30'd0, dth_in_valid, dth_hsync}, 32'd0);
    cyc(); @(negedge clk);
    chk("hsync_reassert", {31'd0, dth_hsync}, 32'd1);
    chk("l1_runs", vrise - r0, 32'd1);
    chk("l1_sb_empty", sb.size(), 32'd0);
    chk("l1_flags", {30'd0, line_short, line_long}, 32'd0);

    // mode change mid-frame must not take effect yet
    cfg_mode = 2'd2;

    // line 2: 2 of 4 groups, padded with fill, no gap
    r0 = vrise;
    grp(32'hA1A2A3A4, 1'b1);
    grp(32'hB1B2B3B4, 1'b1);
    sb.push_back(32'h80808080);
    sb.push_back(32'h80808080);
    idle(8);
    @(negedge clk);
    chk("l2_sb_empty", sb.size(), 32'd0);
    chk("l2_no_gap", vrise - r0, 32'd1);
    chk("l2_short", {30'd0, line_short, line_long}, 32'd2);
    chk("l2_mode_held", {30'd0, mode_q}, 32'd1);
    chk("l2_hsync", {31'd0, dth_hsync}, 32'd1);

    // frame 2: h=3, mode now 2, flags cleared
    cfg_h_groups = 10'd3;
    vin_vsync = 1'b1;
    cyc(); @(negedge clk);
    chk("f2_vsync", {31'd0, dth_vsync}, 32'd1);
    chk("f2_mode", {30'd0, mode_q}, 32'd2);
    chk("f2_flags_clr", {30'd0, line_short, line_long}, 32'd0);
    cyc();
    vin_vsync = 1'b0;

    // line 3: 5 groups, only 3 forwarded
    r0 = vrise;
    for (int k = 0; k < 5; k++) grp(32'hC0C0C000 + k, k < 3);
    idle(8);
    @(negedge clk);
    chk("l3_sb_empty", sb.size(), 32'd0);
    chk("l3_runs", vrise - r0, 32'd1);
    chk("l3_long", {30'd0, line_short, line_long}, 32'd1);

    // line 4: starts clean after the truncated line
    r0 = vrise;
    for (int k = 0; k < 3; k++) grp(32'hD0D0D000 + k, 1'b1);
    idle(8);
    @(negedge clk);
    chk("l4_sb_empty", sb.size(), 32'd0);
    chk("l4_runs", vrise - r0, 32'd1);

    // frame 3: vsync edge while padding
    cfg_h_groups = 10'd4; cfg_mode = 2'd1;
    vin_vsync = 1'b1;
    cyc(); @(negedge clk);
    chk("f3_flags_clr", {30'd0, line_short, line_long}, 32'd0);
    chk("f3_mode", {30'd0, mode_q}, 32'd1);
    cyc();
    vin_vsync = 1'b0;
    cyc();
    r0 = vrise;
    grp(32'hE0E1E2E3, 1'b1);
    vin_de = 1'b0;
    sb.push_back(32'h80808080);
    cyc(); @(negedge clk);
    chk("l5_padding", {30'd0, dth_in_valid, line_short}, 32'd3);
    vin_vsync = 1'b1;
    cyc(); @(negedge clk);
    chk("l5_abort_vsync", {31'd0, dth_vsync}, 32'd1);
    chk("l5_pad_stop", {31'd0, dth_in_valid}, 32'd0);
    chk("l5_flags_clr", {30'd0, line_short, line_long}, 32'd0);
    cyc();
    vin_vsync = 1'b0;
    @(negedge clk);
    chk("l5_vsync_1cyc", {30'd0, dth_vsync, dth_hsync}, 32'd1);
    chk("l5_sb_empty", sb.size(), 32'd0);
    chk("l5_runs", vrise - r0, 32'd1);

    // async reset in the middle of an active line
    grp(32'h11223344, 1'b1);
    @(negedge clk);
    vin_pix = 32'h55667788;
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid_ctl", {24'd0, dth_vsync, dth_hsync, dth_in_valid, out_valid,
                       line_short, line_long, mode_q}, 32'd0);
    chk("rstmid_pix", dth_in, 32'd0);
    cyc(); cyc();
    rst_n = 1'b1;
    act = 1'b0;
    for (int k = 0; k < 6; k++) begin
      vin_de = k[0];
      cyc(); @(negedge clk);
      act = act | dth_vsync | dth_hsync | dth_in_valid | out_valid;
    end
    chk("post_rst_quiet", {31'd0, act}, 32'd0);

    // frame 4: h_groups=0, no valid output, de dropped as long
    cfg_h_groups = 10'd0;
    vin_de = 1'b0;
    vin_vsync = 1'b1;
    cyc(); @(negedge clk);
    chk("f4_vsync", {31'd0, dth_vsync}, 32'd1);
    cyc();
    vin_vsync = 1'b0;
    r0 = vrise;
    grp(32'hF0F0F0F0, 1'b0);
    grp(32'hF1F1F1F1, 1'b0);
    idle(4);
    @(negedge clk);
    chk("h0_no_valid", vrise - r0, 32'd0);
    chk("h0_long", {30'd0, line_short, line_long}, 32'd1);
    chk("h0_hsync", {31'd0, dth_hsync}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/dither_stream_sequencer.md
Name: dither_stream_sequencer

Overview:
- Sits between the video timing front-end and the error diffusion ditherer (4 px/cycle, Y8 in).
- Converts raw vsync/hsync/de into the ditherer's vsync/hsync/in_valid protocol and enforces a fixed active width per line, padding short lines and truncating long ones so the error line buffer stays column-aligned.
- Latches the dither mode at frame boundaries and emits an output-valid strobe aligned to the ditherer's registered output.

Parameters:
- PIXEL_RATE, 4, pixels per cycle.
- INPUT_BITS, 8, bits per input pixel.
- GBITS, 10, width of the pixel-group counter (max 1023 groups per line).
- FLUSH_CYCLES, 2, idle cycles after the last group, before the line-end hsync, so error write-back completes.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- vin_vsync  in  1  frame start, active-high, level.
- vin_hsync  in  1  line start, active-high, level.
- vin_de  in  1  source data enable.
- vin_pix  in  INPUT_BITS*PIXEL_RATE  source pixel group.
- cfg_h_groups  in  GBITS  active pixel groups per line; sampled at frame start.
- cfg_mode  in  2  0=bypass, 1=Y4, 2=Y1, 3=reserved (treated as bypass); sampled at frame start.
- cfg_fill  in  INPUT_BITS  pad pixel value.
- dth_vsync  out  1  ditherer vsync.
- dth_hsync  out  1  ditherer hsync.
- dth_in_valid  out  1  ditherer in_valid.
- dth_in  out  INPUT_BITS*PIXEL_RATE  ditherer pixel input.
- mode_q  out  2  mode latched for the current frame.
- out_valid  out  1  the ditherer output register holds a valid group.
- line_short  out  1  sticky: a line ended with fewer groups than configured and was padded.
- line_long  out  1  sticky: a line carried excess groups, which were dropped.

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0, mode_q 0.
- All outputs are registered. dth_in is vin_pix delayed 1 cycle, or fill data when padding.
- out_valid = dth_in_valid delayed 1 cycle, matching the ditherer's registered out.
- States and transitions:
  - IDLE: wait for a rising edge of vin_vsync -> VSYNC.
  - VSYNC: dth_vsync=1 for exactly 1 cycle; latch cfg_h_groups, cfg_mode, cfg_fill; clear sticky flags -> WAIT_DE.
  - WAIT_DE: dth_hsync=1 every cycle (holds ditherer error registers clear).
    - vin_de=1 -> ACTIVE, first group forwarded.
    - vin_vsync rising edge -> VSYNC.
  - ACTIVE: forward each vin_de group with dth_in_valid=1; gcnt increments.
    - gcnt reaches h_groups -> FLUSH; further de groups on that line are dropped and set line_long.
    - vin_de falls with gcnt<h_groups -> PAD.
  - PAD: emit fill groups (all lanes = cfg_fill) with dth_in_valid=1 until gcnt=h_groups; set line_short -> FLUSH.
  - FLUSH: FLUSH_CYCLES cycles with dth_in_valid=0, dth_hsync=0 -> WAIT_DE.
- dth_in_valid never gaps inside a line: source de gaps inside ACTIVE are treated as line end and padded.
- h_groups=0: the frame runs with no valid output. VSYNC -> WAIT_DE, and any de is dropped with line_long set.
- vin_vsync rising edge in ACTIVE/PAD/FLUSH: abort the line and go to VSYNC. No further pad groups are emitted. A write-back still in flight is allowed to finish.
- Simultaneous vin_vsync rising edge and vin_de: vsync wins; that de group is dropped.
- Mode bypass/3: sequencing is unchanged; mode_q tells the downstream mux to select raw pixels.
- Async reset mid-line: immediate return to IDLE, all outputs 0. The next frame needs a vsync edge.

Optional Feature:
- DITHER_SEQ_STATS_EN.
- Defined: adds outputs frame_cnt[15:0] (increments in VSYNC, wraps) and pad_cnt[15:0] (increments per padded group, saturates at 0xFFFF, clears at reset only).
- Undefined: those ports and counters are absent and the behaviour is otherwise identical.

Decomposition:
- Shared package dither_pkg:
  - mode enum: DM_BYPASS, DM_Y4, DM_Y1.
  - state enum: IDLE, VSYNC, WAIT_DE, ACTIVE, PAD, FLUSH.
  - constants for default FLUSH_CYCLES and PIXEL_RATE.
- One natural sub-module: dither_seq_delay, a parameterised valid/data delay line used for out_valid alignment.

Test Plan:
- h_groups=4, de for 4 groups 0x10203040.. -> dth_in_valid high 4 cycles, 1-cycle delayed; out_valid 1 cycle later; 2 flush cycles; dth_hsync re-asserts.
- h_groups=4, de for 2 groups, cfg_fill=0x80 -> 2 groups of 0x80808080 follow with no gap; line_short=1.
- h_groups=3, de for 5 groups -> exactly 3 valid groups, line_long=1; next line starts clean.
- cfg_mode 1 -> 2 changed mid-frame -> mode_q stays 1 until the next vsync, then 2.
- vsync edge during PAD at gcnt=1 of 4 -> padding stops, dth_vsync pulses 1 cycle, flags clear.
- rst_n low mid-ACTIVE -> all outputs 0 the same cycle; no activity until the next vsync edge.
